// File: rtl/sram_1r1w_init_if.sv
// Read/write port bundle for sram_1r1w_init.
// The master drives requests; the slave (the array) returns data and ready.
interface sram_1r1w_init_if #(
  parameter int ADDR_W   = 9,
  parameter int WIDTH    = 2,
  parameter int MASK_SEG = 1
);
  logic [ADDR_W-1:0]   R0_addr;
  logic                R0_en;
  logic [WIDTH-1:0]    R0_data;
  logic [ADDR_W-1:0]   W0_addr;
  logic                W0_en;
  logic [WIDTH-1:0]    W0_data;
  logic [MASK_SEG-1:0] W0_mask;
  logic                ready;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, ready
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, ready
  );
endinterface

// File: rtl/sram_1r1w_init.sv
// 1R1W masked SRAM with post-reset init sweep,
// per-lane write-first bypass and held read data.
module sram_1r1w_init #(
  parameter int              DEPTH     = 512,
  parameter int              WIDTH     = 2,
  parameter int              MASK_GRAN = 2,
  parameter int              MASK_SEG  = WIDTH / MASK_GRAN,
  parameter int              ADDR_W    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic              clock,
  input logic              reset,
  sram_1r1w_init_if.slave  bus
);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [WIDTH-1:0]    wdata;
  logic [MASK_SEG-1:0] wmask;
  logic                wr_ok, rd_ok, hit;
  logic [WIDTH-1:0]    rd_word;

  assign wr_ok = {1'b0, bus.W0_addr} < DEPTH_L;
  assign rd_ok = {1'b0, bus.R0_addr} < DEPTH_L;
  assign hit   = bus.W0_en && wr_ok && (bus.W0_addr == bus.R0_addr);

  // Read word with same-cycle write merged in lane by lane
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.R0_addr];
      for (int i = 0; i < MASK_SEG; i++) begin
        if (hit && bus.W0_mask[i]) begin
          rd_word[i*MASK_GRAN +: MASK_GRAN] =
            bus.W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Next state, sweep counter, write port mux and read register
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rdata_d    = rdata_q;
    we         = 1'b0;
    waddr      = init_cnt_q;
    wdata      = INIT_VAL;
    wmask      = '1;
    unique case (state_q)
      S_INIT: begin
        we = 1'b1;
        if (init_cnt_q == LAST) begin
          state_d    = S_READY;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      S_READY: begin
        we    = bus.W0_en && wr_ok;
        waddr = bus.W0_addr;
        wdata = bus.W0_data;
        wmask = bus.W0_mask;
        if (bus.R0_en) rdata_d = rd_word;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control and read-data registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage array: lane-masked write, contents survive reset
  always_ff @(posedge clock) begin
    if (we && !reset) begin
      for (int i = 0; i < MASK_SEG; i++) begin
        if (wmask[i]) begin
          mem[waddr][i*MASK_GRAN +: MASK_GRAN] <=
            wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  assign bus.R0_data = rdata_q;
  assign bus.ready   = (state_q == S_READY);

endmodule
